// File: rtl/prl_pkg.sv
// prl_pkg: shared encodings for the PD protocol-layer hard/cable reset controller
package prl_pkg;
  typedef enum logic [6:0] {
    IDLE      = 7'b0000001,
    WAIT_REQ  = 7'b0000010,
    CONSTRUCT = 7'b0000100,
    WAIT_ACK  = 7'b0001000,
    SUCCESS   = 7'b0010000,
    FAILURE   = 7'b0100000,
    REPORT    = 7'b1000000
  } prl_state_t;
  localparam logic [2:0] TX_HARD  = 3'b101;
  localparam logic [2:0] TX_CABLE = 3'b110;
  localparam int ALERT_TX_FAIL = 4;
  localparam int ALERT_TX_OK   = 6;
endpackage

// File: rtl/prl_cycle_timer.sv
// prl_cycle_timer: clearable up-counter flagging a programmable terminal count
module prl_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= !rst_ni ? '0 : cnt_d;
  assign expired_o = en_i && cnt_q == tc_i;
endmodule

// File: rtl/prl_hard_reset_ctrl.sv
// prl_hard_reset_ctrl: issues hard/cable reset signalling to the PHY with timed retries
module prl_hard_reset_ctrl
  import prl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int N_RETRY        = 2,
  parameter int ALERT_W        = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic [15:0]        iAlert,
  input  logic [7:0]         ioTRANSMIT,
  input  logic               PHY_ACK,
  input  logic [ALERT_W-1:0] alert_clr,
  output logic [7:0]         oTRANSMIT,
  output logic [ALERT_W-1:0] ALERT,
  output logic [7:0]         oRECEIVE_DETECT,
  output logic [7:0]         oRECEIVE_BYTE_COUNT,
  output logic               PHY_Stop_Attempting_Reset,
  output logic               busy,
  output logic [2:0]         attempt_cnt
);
  prl_state_t         state_q;
  logic [7:0]         tx_q, det_q, cnt_q;
  logic [ALERT_W-1:0] alert_q, alert_d;
  logic [4:0]         hi_q;
  logic [2:0]         att_q;
  logic               cable_q, ok_q, stop_q, busy_q, expired;
  logic               unused_alert;
  assign unused_alert = ^{iAlert[15:4], iAlert[2:0]};
  prl_cycle_timer #(.W(8)) u_timer (
    .clk_i    (CLK),
    .rst_ni   (reset),
    .clr_i    (state_q == CONSTRUCT),
    .en_i     (state_q == WAIT_ACK),
    .tc_i     (8'(TIMEOUT_CYCLES - 1)),
    .expired_o(expired)
  );
  always_comb alert_d = (alert_q & ~alert_clr) |
                        (ALERT_W'(state_q == REPORT) << (ok_q ? ALERT_TX_OK : ALERT_TX_FAIL));
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= IDLE;
      tx_q    <= '0;
      det_q   <= '0;
      cnt_q   <= '0;
      alert_q <= '0;
      hi_q    <= '0;
      att_q   <= '0;
      cable_q <= 1'b0;
      ok_q    <= 1'b0;
      stop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      alert_q <= alert_d;
      unique case (state_q)
        IDLE: state_q <= WAIT_REQ;
        WAIT_REQ: if (iAlert[3]) begin
          state_q <= CONSTRUCT;
          cable_q <= ioTRANSMIT[2:0] == TX_CABLE;
          hi_q    <= ioTRANSMIT[7:3];
          att_q   <= '0;
          stop_q  <= 1'b0;
          busy_q  <= 1'b1;
        end
        CONSTRUCT: begin
          state_q <= WAIT_ACK;
          tx_q    <= {hi_q, cable_q ? TX_CABLE : TX_HARD};
          cnt_q   <= {7'd0, cable_q};
          det_q   <= '0;
          att_q   <= att_q + 3'd1;
        end
        WAIT_ACK: begin
          if (PHY_ACK) state_q <= SUCCESS;
          else if (expired) state_q <= att_q <= 3'(N_RETRY) ? CONSTRUCT : FAILURE;
        end
        SUCCESS: begin
          state_q <= REPORT;
          ok_q    <= 1'b1;
        end
        FAILURE: begin
          state_q <= REPORT;
          ok_q    <= 1'b0;
          stop_q  <= 1'b1;
        end
        REPORT: begin
          state_q <= WAIT_REQ;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign oTRANSMIT                 = tx_q;
  assign ALERT                     = alert_q;
  assign oRECEIVE_DETECT           = det_q;
  assign oRECEIVE_BYTE_COUNT       = cnt_q;
  assign PHY_Stop_Attempting_Reset = stop_q;
  assign busy                      = busy_q;
  assign attempt_cnt               = att_q;
endmodule

// File: tb/tb_prl_hard_reset_ctrl.sv
// tb_prl_hard_reset_ctrl: directed vectors for the hard/cable reset controller
module tb_prl_hard_reset_ctrl;
  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] iAlert = '0;
  logic [7:0]  ioTRANSMIT = '0;
  logic        PHY_ACK = 1'b0;
  logic [15:0] alert_clr = '0;
  logic [7:0]  oTRANSMIT, oRECEIVE_DETECT, oRECEIVE_BYTE_COUNT;
  logic [15:0] ALERT;
  logic        PHY_Stop_Attempting_Reset, busy;
  logic [2:0]  attempt_cnt;
  int checks = 0;
  int errors = 0;

  prl_hard_reset_ctrl #(.TIMEOUT_CYCLES(8), .N_RETRY(2), .ALERT_W(16)) dut (
    .CLK(CLK), .reset(reset), .iAlert(iAlert), .ioTRANSMIT(ioTRANSMIT),
    .PHY_ACK(PHY_ACK), .alert_clr(alert_clr), .oTRANSMIT(oTRANSMIT), .ALERT(ALERT),
    .oRECEIVE_DETECT(oRECEIVE_DETECT), .oRECEIVE_BYTE_COUNT(oRECEIVE_BYTE_COUNT),
    .PHY_Stop_Attempting_Reset(PHY_Stop_Attempting_Reset), .busy(busy),
    .attempt_cnt(attempt_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_alert();
    alert_clr = 16'hFFFF;
    step(1);
    alert_clr = '0;
  endtask

  initial begin
    step(2);
    check("rst_tx", 32'(oTRANSMIT), 32'h00);
    check("rst_alert", 32'(ALERT), 32'h0000);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_att", 32'(attempt_cnt), 32'd0);
    check("rst_stop", 32'(PHY_Stop_Attempting_Reset), 32'd0);
    check("rst_cnt", 32'(oRECEIVE_BYTE_COUNT), 32'd0);
    reset = 1'b1;
    step(1);
    // hard reset, ACK on third WAIT_ACK cycle
    ioTRANSMIT = 8'h05;
    iAlert = 16'h0008;
    step(1);
    iAlert = '0;
    check("hard_busy", 32'(busy), 32'd1);
    step(1);
    check("hard_tx", 32'(oTRANSMIT), 32'h05);
    check("hard_att", 32'(attempt_cnt), 32'd1);
    step(2);
    PHY_ACK = 1'b1;
    step(1);
    PHY_ACK = 1'b0;
    step(1);
    check("hard_alert_early", 32'(ALERT), 32'h0000);
    step(1);
    check("hard_alert", 32'(ALERT), 32'h0040);
    check("hard_cnt", 32'(oRECEIVE_BYTE_COUNT), 32'd0);
    check("hard_att_end", 32'(attempt_cnt), 32'd1);
    check("hard_idle", 32'(busy), 32'd0);
    clear_alert();
    check("alert_w1c", 32'(ALERT), 32'h0000);
    // cable reset, ACK held from the start, alert_clr in REPORT
    ioTRANSMIT = 8'hF6;
    iAlert = 16'h0008;
    PHY_ACK = 1'b1;
    step(1);
    iAlert = '0;
    step(3);
    check("cable_edge4", 32'(ALERT), 32'h0000);
    alert_clr = 16'h0040;
    step(1);
    PHY_ACK = 1'b0;
    check("cable_edge5", 32'(ALERT), 32'h0040);
    check("cable_tx", 32'(oTRANSMIT), 32'hF6);
    check("cable_cnt", 32'(oRECEIVE_BYTE_COUNT), 32'd1);
    check("cable_det", 32'(oRECEIVE_DETECT), 32'd0);
    step(1);
    alert_clr = '0;
    check("clr_after", 32'(ALERT), 32'h0000);
    // no ACK: three attempts then failure
    ioTRANSMIT = 8'h05;
    iAlert = 16'h0008;
    step(1);
    iAlert = '0;
    step(10);
    check("fail_att2", 32'(attempt_cnt), 32'd2);
    step(17);
    check("fail_stop_pre", 32'(PHY_Stop_Attempting_Reset), 32'd0);
    step(1);
    check("fail_stop", 32'(PHY_Stop_Attempting_Reset), 32'd1);
    check("fail_alert_pre", 32'(ALERT), 32'h0000);
    step(1);
    check("fail_alert", 32'(ALERT), 32'h0010);
    check("fail_att3", 32'(attempt_cnt), 32'd3);
    check("fail_idle", 32'(busy), 32'd0);
    clear_alert();
    check("stop_held", 32'(PHY_Stop_Attempting_Reset), 32'd1);
    iAlert = 16'h0008;
    step(1);
    iAlert = '0;
    check("stop_clr", 32'(PHY_Stop_Attempting_Reset), 32'd0);
    check("att_clr", 32'(attempt_cnt), 32'd0);
    PHY_ACK = 1'b1;
    step(4);
    PHY_ACK = 1'b0;
    check("retry_ok", 32'(ALERT), 32'h0040);
    clear_alert();
    // ACK coincident with the last window cycle of attempt 2
    iAlert = 16'h0008;
    step(1);
    iAlert = '0;
    step(17);
    PHY_ACK = 1'b1;
    step(1);
    PHY_ACK = 1'b0;
    step(2);
    check("tie_alert", 32'(ALERT), 32'h0040);
    check("tie_att", 32'(attempt_cnt), 32'd2);
    check("tie_stop", 32'(PHY_Stop_Attempting_Reset), 32'd0);
    clear_alert();
    // reset during WAIT_ACK
    iAlert = 16'h0008;
    step(1);
    iAlert = '0;
    step(3);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    step(1);
    check("mid_tx", 32'(oTRANSMIT), 32'h00);
    check("mid_busy0", 32'(busy), 32'd0);
    check("mid_att", 32'(attempt_cnt), 32'd0);
    check("mid_cnt", 32'(oRECEIVE_BYTE_COUNT), 32'd0);
    iAlert = 16'h0008;
    reset = 1'b1;
    step(1);
    check("idle_ignores", 32'(busy), 32'd0);
    step(1);
    iAlert = '0;
    check("accept_after_idle", 32'(busy), 32'd1);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(6);
    check("mid_alert", 32'(ALERT), 32'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
